cla_addsub_pipe: RTL and testbench



---
 rtl/cla_addsub_pipe_pkg.sv | 17 +
 rtl/cla_group.sv | 44 ++++
 rtl/cla_addsub_pipe.sv | 136 +++++++++++++
 tb/tb_cla_addsub_pipe.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cla_addsub_pipe_pkg.sv
// rtl/cla_addsub_pipe_pkg.sv - shared encodings and parameter check for the pipelined CLA adder/subtractor
`ifndef CLA_ADDSUB_PIPE_PKG_SV
`define CLA_ADDSUB_PIPE_PKG_SV

`define CLA_CHECK_WIDTH(W, G) \
    if (((W) % (G)) != 0) begin : g_width_check \
        $error("cla_addsub_pipe: WIDTH must be a multiple of GROUP"); \
    end

package cla_addsub_pipe_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

`endif

// File: rtl/cla_group.sv
// rtl/cla_group.sv - GROUP-bit combinational carry-lookahead slice
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] s,
    output logic             cout,
    output logic             gout,
    output logic             pout
);

    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] gg;
    logic [GROUP-1:0] pp;
    logic [GROUP:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // gg[i]/pp[i] are the generate/propagate of bits i..0, each carry formed directly from cin
    always_comb begin
        gg = '0;
        pp = '0;
        for (int i = 0; i < GROUP; i++) begin
            gg[i] = g[i];
            pp[i] = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                gg[i] = gg[i] | (pp[i] & g[j]);
                pp[i] = pp[i] & p[j];
            end
        end
    end

    assign c[0]       = cin;
    assign c[GROUP:1] = gg | (pp & {GROUP{cin}});
    assign s          = p ^ c[GROUP-1:0];
    assign cout       = c[GROUP];
    assign gout       = gg[GROUP-1];
    assign pout       = pp[GROUP-1];

endmodule

// File: rtl/cla_addsub_pipe.sv
// rtl/cla_addsub_pipe.sv - pipelined carry-lookahead adder/subtractor, one GROUP-bit slice per stage
module cla_addsub_pipe #(
    parameter int WIDTH = 32,
    parameter int GROUP = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);
    import cla_addsub_pipe_pkg::*;

    localparam int NS = WIDTH / GROUP;

    `CLA_CHECK_WIDTH(WIDTH, GROUP)

    logic             stall;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    logic             valid_q [NS];
    logic             carry_q [NS];
    logic [WIDTH-1:0] a_q     [NS];
    logic [WIDTH-1:0] b_q     [NS];
    logic [WIDTH-1:0] sum_q   [NS];
    logic [TAG_W-1:0] tag_q   [NS];
    logic             zero_q;
    logic             ovf_q;

    assign b_eff   = (in_op == OP_SUB) ? ~in_b : in_b;
    assign cin_eff = (in_op == OP_SUB) ? ~in_cin : in_cin;

    assign stall    = valid_q[NS-1] && !out_ready;
    assign in_ready = !stall;

    for (genvar k = 0; k < NS; k++) begin : g_stage
        logic             v_src;
        logic             c_src;
        logic [WIDTH-1:0] a_src;
        logic [WIDTH-1:0] b_src;
        logic [WIDTH-1:0] sum_src;
        logic [WIDTH-1:0] sum_d;
        logic [TAG_W-1:0] tag_src;
        logic [GROUP-1:0] s;
        logic             cout;
        logic             gout;
        logic             pout;
        logic             unused_gp;

        if (k == 0) begin : g_head
            assign v_src   = in_valid;
            assign c_src   = cin_eff;
            assign a_src   = in_a;
            assign b_src   = b_eff;
            assign sum_src = '0;
            assign tag_src = in_tag;
        end else begin : g_body
            assign v_src   = valid_q[k-1];
            assign c_src   = carry_q[k-1];
            assign a_src   = a_q[k-1];
            assign b_src   = b_q[k-1];
            assign sum_src = sum_q[k-1];
            assign tag_src = tag_q[k-1];
        end

        cla_group #(.GROUP(GROUP)) u_cla (
            .a    (a_src[k*GROUP +: GROUP]),
            .b    (b_src[k*GROUP +: GROUP]),
            .cin  (c_src),
            .s    (s),
            .cout (cout),
            .gout (gout),
            .pout (pout)
        );

        assign unused_gp = gout ^ pout;

        always_comb begin
            sum_d = sum_src;
            sum_d[k*GROUP +: GROUP] = s;
        end

        // Operands travel whole; bits below the current slice are dead and trimmed in synthesis.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q[k] <= 1'b0;
                carry_q[k] <= 1'b0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                sum_q[k]   <= '0;
                tag_q[k]   <= '0;
            end else if (!stall) begin
                valid_q[k] <= v_src;
                carry_q[k] <= cout;
                a_q[k]     <= a_src;
                b_q[k]     <= b_src;
                sum_q[k]   <= sum_d;
                tag_q[k]   <= tag_src;
            end
        end

        if (k == NS - 1) begin : g_flags
            always_ff @(posedge clk) begin
                if (rst) begin
                    zero_q <= 1'b0;
                    ovf_q  <= 1'b0;
                end else if (!stall) begin
                    zero_q <= (sum_d == '0);
                    ovf_q  <= (a_src[WIDTH-1] == b_src[WIDTH-1]) &&
                              (sum_d[WIDTH-1] != a_src[WIDTH-1]);
                end
            end
        end
    end

    assign out_valid = valid_q[NS-1];
    assign out_sum   = sum_q[NS-1];
    assign out_carry = carry_q[NS-1];
    assign out_tag   = tag_q[NS-1];
    assign out_zero  = zero_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// tb/tb_cla_addsub_pipe.sv - directed and streaming checks for cla_addsub_pipe
module tb_cla_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_cin;
    logic        in_op;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_carry;
    logic        out_ovf;
    logic        out_zero;
    logic [3:0]  out_tag;

    int n_tests = 0;
    int n_fail  = 0;

    logic [38:0] exp_q[$];

    cla_addsub_pipe #(.WIDTH(32), .GROUP(4), .TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, carry as "no borrow" for subtract.
    function automatic logic [38:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic op, input logic [3:0] tag);
        logic [33:0] wide;
        longint      sres;
        logic [31:0] s;
        logic        c;
        logic        v;
        if (!op) begin
            wide = {2'b00, a} + {2'b00, b} + {33'd0, cin};
            c    = wide[32];
            sres = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        end else begin
            wide = {2'b00, a} - {2'b00, b} - {33'd0, cin};
            c    = ({1'b0, a} >= ({1'b0, b} + {32'd0, cin}));
            sres = longint'($signed(a)) - longint'($signed(b)) - longint'(cin);
        end
        s = wide[31:0];
        v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        return {tag, c, v, (s == 32'd0), s};
    endfunction

    function automatic logic [38:0] cur_out();
        return {out_tag, out_carry, out_ovf, out_zero, out_sum};
    endfunction

    task automatic run_one(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic op, input logic [3:0] tag,
                           input logic [31:0] e_sum, input logic e_c, input logic e_v,
                           input logic e_z);
        int lat;
        @(negedge clk);
        in_a = a; in_b = b; in_cin = cin; in_op = op; in_tag = tag;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({nm, "_lat"},   64'(lat), 64'd8);
        check({nm, "_sum"},   64'(out_sum), 64'(e_sum));
        check({nm, "_carry"}, 64'(out_carry), 64'(e_c));
        check({nm, "_ovf"},   64'(out_ovf), 64'(e_v));
        check({nm, "_zero"},  64'(out_zero), 64'(e_z));
        check({nm, "_tag"},   64'(out_tag), 64'(tag));
        @(posedge clk);
    endtask

    // Streams n random beats; optionally drops out_ready for stall_len cycles once outputs flow.
    task automatic run_stream(input string nm, input int n, input int stall_len);
        logic [31:0] va[$];
        logic [31:0] vb[$];
        logic        vc[$];
        logic        vo[$];
        logic [38:0] snap;
        logic        have_snap;
        int sent, got, cyc, first_out, last_out, stall_left;
        for (int i = 0; i < n; i++) begin
            va.push_back($urandom);
            vb.push_back($urandom);
            vc.push_back(1'($urandom_range(0, 1)));
            vo.push_back(1'($urandom_range(0, 1)));
        end
        exp_q.delete();
        sent = 0; got = 0; cyc = 0; first_out = -1; last_out = -1;
        stall_left = stall_len; have_snap = 1'b0; snap = '0;
        while (got < n && cyc < 400) begin
            @(negedge clk);
            if (first_out >= 0 && cyc >= first_out + 2 && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            if (sent < n) begin
                in_a = va[sent]; in_b = vb[sent]; in_cin = vc[sent]; in_op = vo[sent];
                in_tag = 4'(sent);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!out_ready) begin
                check({nm, "_stall_in_ready"}, 64'(in_ready), 64'd0);
                if (have_snap) check({nm, "_stall_hold"}, 64'(cur_out()), 64'(snap));
                snap = cur_out();
                have_snap = 1'b1;
            end else begin
                have_snap = 1'b0;
            end
            if (out_valid && first_out < 0) first_out = cyc;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check({nm, "_spurious"}, 64'(cur_out()), 64'd0);
                end else begin
                    check({nm, "_result"}, 64'(cur_out()), 64'(exp_q.pop_front()));
                end
                got++;
                last_out = cyc;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_a, in_b, in_cin, in_op, in_tag));
                sent++;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        check({nm, "_count"}, 64'(got), 64'(n));
        check({nm, "_leftover"}, 64'(exp_q.size()), 64'd0);
        check({nm, "_first_out"}, 64'(first_out), 64'd8);
        if (stall_len == 0) check({nm, "_span"}, 64'(last_out - first_out), 64'(n - 1));
        else                check({nm, "_span"}, 64'(last_out - first_out), 64'(n - 1 + stall_len));
    endtask

    initial begin
        int seen;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
        in_op = 1'b0; in_tag = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outputs",   64'(cur_out()), 64'd0);
        @(negedge clk);
        check("rst_in_ready",  64'(in_ready), 64'd1);

        run_one("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'd3, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_one("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'd5, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_one("add_cin",  32'h0000_000F, 32'h0000_0001, 1'b1, 1'b0, 4'd6, 32'h0000_0011, 1'b0, 1'b0, 1'b0);
        run_one("sub_neg",  32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 4'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_one("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 4'd8, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        run_one("sub_bin",  32'h0000_0009, 32'h0000_0004, 1'b1, 1'b1, 4'd9, 32'h0000_0004, 1'b1, 1'b0, 1'b0);

        run_stream("stream", 20, 0);
        run_stream("stall",  12, 5);

        // Six beats in flight, then a one-cycle reset must flush them all.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_a = 32'(i + 1); in_b = 32'd100; in_cin = 1'b0; in_op = 1'b0;
            in_tag = 4'(i); in_valid = 1'b1; out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_outputs",   64'(cur_out()), 64'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush_no_partial", 64'(seen), 64'd0);
        run_one("post_rst", 32'd3, 32'd4, 1'b0, 1'b0, 4'd2, 32'd7, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
